// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared definitions for the RV32 instruction encoder / program loader.
//   - Format codes (same values as the controller's ImmSel).
//   - Opcode constants, the nop and halt words.
//   - Loader FSM state encoding.
//   - fits_signed(): true when a 32-bit value is representable as a
//     'bits'-wide two's-complement number.
package rv32_pkg;

  localparam logic [2:0] FMT_R = 3'b000;
  localparam logic [2:0] FMT_I = 3'b001;
  localparam logic [2:0] FMT_S = 3'b010;
  localparam logic [2:0] FMT_B = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_J = 3'b101;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // addi x0,x0,0 and jal x0,0
  localparam logic [31:0] NOP_WORD  = {20'h0, 5'd0, OP_IMM};
  localparam logic [31:0] HALT_WORD = {20'h0, 5'd0, OP_JAL};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Every bit from (bits-1) upward must equal the sign bit.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == 32'h0) || (hi == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/rv32_instr_encoder_if.sv
// rv32_instr_encoder_if
// Bundle of the loader's session control, request handshake, memory
// write port and status flags.
//   master : request producer (drives i_*, observes o_*)
//   slave  : the encoder (observes i_*, drives o_*)
// IMEM_AW must match the encoder instance it connects to.
interface rv32_instr_encoder_if #(parameter int IMEM_AW = 8);

  logic               i_start;
  logic               i_finish;
  logic               i_valid;
  logic               o_ready;
  logic [2:0]         i_fmt;
  logic [6:0]         i_opcode;
  logic [2:0]         i_funct3;
  logic               i_funct7_5;
  logic [4:0]         i_rd;
  logic [4:0]         i_rs1;
  logic [4:0]         i_rs2;
  logic [31:0]        i_imm;
  logic               o_mem_we;
  logic [IMEM_AW-1:0] o_mem_addr;
  logic [31:0]        o_mem_wdata;
  logic [IMEM_AW:0]   o_count;
  logic               o_err;
  logic               o_full;
  logic               o_done;

  modport master (
    output i_start, i_finish, i_valid, i_fmt, i_opcode, i_funct3, i_funct7_5,
           i_rd, i_rs1, i_rs2, i_imm,
    input  o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_err, o_full, o_done
  );

  modport slave (
    input  i_start, i_finish, i_valid, i_fmt, i_opcode, i_funct3, i_funct7_5,
           i_rd, i_rs1, i_rs2, i_imm,
    output o_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_err, o_full, o_done
  );

endinterface

// File: rtl/rv32_imm_pack.sv
// rv32_imm_pack
// Combinational packing of one field-level request into an RV32I word,
// plus the legality check. Illegal requests produce the nop word.
//   fmt/op/f3/f7_5/rd/rs1/rs2/imm : request fields
//   word    : encoded instruction (nop when illegal)
//   illegal : request cannot be encoded
module rv32_imm_pack
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  op,
  input  logic [2:0]  f3,
  input  logic        f7_5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic        shift_form;
  logic [31:0] raw;

  // Immediate shifts carry a 5-bit shamt plus the sra/srl selector in bit 30.
  assign shift_form = (op == OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101));

  always_comb begin
    raw     = 32'h0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: raw = {1'b0, f7_5, 5'b0, rs2, rs1, f3, rd, op};
      FMT_I: begin
        if (shift_form) begin
          raw     = {1'b0, f7_5, 5'b0, imm[4:0], rs1, f3, rd, op};
          illegal = |imm[31:5];
        end else begin
          raw     = {imm[11:0], rs1, f3, rd, op};
          illegal = !fits_signed(imm, 12);
        end
      end
      FMT_S: begin
        raw     = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        illegal = !fits_signed(imm, 12);
      end
      FMT_B: begin
        raw     = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        illegal = imm[0] || !fits_signed(imm, 13);
      end
      FMT_U: begin
        raw     = {imm[31:12], rd, op};
        illegal = |imm[11:0];
      end
      FMT_J: begin
        raw     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        illegal = imm[0] || !fits_signed(imm, 21);
      end
      default: illegal = 1'b1;
    endcase
    // All RV32I opcodes end in 2'b11; anything else is a compressed/invalid encoding.
    if (op[1:0] != 2'b11) illegal = 1'b1;
    word = illegal ? NOP_WORD : raw;
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder
// Program loader: accepts field-level requests, encodes them and writes
// them to consecutive instruction-memory words, then appends a halt word.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)    : session control, request handshake, memory write
//                    port and count/err/full/done status
// Parameters:
//   IMEM_AW   : word-address width, DEPTH = 2**IMEM_AW
//   BASE_ADDR : first word address written in a session
// Pipeline: accept edge -> field register -> encoded-word register ->
// memory write register, so the write strobe is high in the cycle after
// the second edge following acceptance.
module rv32_instr_encoder
  import rv32_pkg::*;
#(
  parameter int IMEM_AW   = 8,
  parameter int BASE_ADDR = 0
)(
  input  logic i_clk,
  input  logic i_rst_n,
  rv32_instr_encoder_if.slave bus
);

  localparam int DEPTH = 1 << IMEM_AW;
  localparam logic [IMEM_AW-1:0] BASE       = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW:0]   FULL_COUNT = (IMEM_AW + 1)'(DEPTH - 1);

  logic [2:0]         state;
  logic [IMEM_AW-1:0] ptr;
  logic [IMEM_AW:0]   count;
  logic               err;
  logic               full;
  logic               accept;
  logic               pipe_empty;

  logic               s1_valid;
  logic [2:0]         s1_fmt;
  logic [6:0]         s1_op;
  logic [2:0]         s1_f3;
  logic               s1_f7_5;
  logic [4:0]         s1_rd, s1_rs1, s1_rs2;
  logic [31:0]        s1_imm;
  logic [IMEM_AW-1:0] s1_addr;

  logic               s2_valid;
  logic [31:0]        s2_word;
  logic               s2_illegal;
  logic [IMEM_AW-1:0] s2_addr;

  logic [31:0]        pack_word;
  logic               pack_illegal;

  logic               mem_we;
  logic [IMEM_AW-1:0] mem_addr;
  logic [31:0]        mem_wdata;

  // The last slot is kept for the halt word.
  assign full       = (count == FULL_COUNT);
  assign pipe_empty = !s1_valid && !s2_valid;
  // A request presented together with i_finish is still taken, even though
  // o_ready already drops for that cycle to tell the producer to stop.
  assign accept     = (state == ST_LOAD) && bus.i_valid && !full;

  rv32_imm_pack u_pack (
    .fmt     (s1_fmt),
    .op      (s1_op),
    .f3      (s1_f3),
    .f7_5    (s1_f7_5),
    .rd      (s1_rd),
    .rs1     (s1_rs1),
    .rs2     (s1_rs2),
    .imm     (s1_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Session FSM with the write pointer, accept counter and sticky error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      ptr   <= BASE;
      count <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            state <= ST_LOAD;
            ptr   <= BASE;
            count <= '0;
            err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            ptr   <= ptr + 1'b1;
            count <= count + 1'b1;
          end
          if (bus.i_finish) state <= ST_DRAIN;
        end
        ST_DRAIN: if (pipe_empty) state <= ST_HALT;
        ST_HALT:  state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
      // Raised together with the nop write so the flag lines up with it.
      if (s2_valid && s2_illegal) err <= 1'b1;
    end
  end

  // Field register and encoded-word register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_fmt     <= '0;
      s1_op      <= '0;
      s1_f3      <= '0;
      s1_f7_5    <= 1'b0;
      s1_rd      <= '0;
      s1_rs1     <= '0;
      s1_rs2     <= '0;
      s1_imm     <= '0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_word    <= '0;
      s2_illegal <= 1'b0;
      s2_addr    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_fmt  <= bus.i_fmt;
        s1_op   <= bus.i_opcode;
        s1_f3   <= bus.i_funct3;
        s1_f7_5 <= bus.i_funct7_5;
        s1_rd   <= bus.i_rd;
        s1_rs1  <= bus.i_rs1;
        s1_rs2  <= bus.i_rs2;
        s1_imm  <= bus.i_imm;
        s1_addr <= ptr;
      end
      s2_valid   <= s1_valid;
      s2_word    <= pack_word;
      s2_illegal <= pack_illegal;
      s2_addr    <= s1_addr;
    end
  end

  // Memory write register; the halt word is loaded on the edge that moves
  // DRAIN into HALT, so its strobe is visible during HALT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (s2_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= s2_addr;
        mem_wdata <= s2_word;
      end else if ((state == ST_DRAIN) && pipe_empty) begin
        mem_we    <= 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= HALT_WORD;
      end
    end
  end

  assign bus.o_ready     = (state == ST_LOAD) && !full && !bus.i_finish;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_count     = count;
  assign bus.o_err       = err;
  assign bus.o_full      = full;
  assign bus.o_done      = (state == ST_DONE);

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// tb_rv32_instr_encoder
// Scoreboard bench for the RV32 program loader. A small memory (DEPTH 8)
// with a non-zero base address makes the wrap and full conditions cheap
// to reach. Expected writes are queued at issue; a negedge monitor pops
// and compares every write strobe.
module tb_rv32_instr_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int BASE  = 5;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32_instr_encoder_if #(.IMEM_AW(AW)) bus ();

  rv32_instr_encoder #(.IMEM_AW(AW), .BASE_ADDR(BASE)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   m_count    = 0;
  bit   m_load     = 1'b0;
  bit   m_err      = 1'b0;
  int   bl[15] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                   1048574, 1048576, -1048576, 31, 32, 4096, 0};

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference encoder written from the instruction-format rules with plain
  // integer arithmetic; returns {illegal, word}.
  function automatic logic [32:0] ref_encode(input req_t r);
    logic [31:0] w;
    bit          bad;
    int          s;
    s   = $signed(r.imm);
    w   = 32'h0;
    bad = (r.fmt > 3'd5) || (r.op[1:0] != 2'b11);
    case (r.fmt)
      3'd0: w = 32'(r.f75) << 30 | 32'(r.rs2) << 20 | 32'(r.rs1) << 15 |
                32'(r.f3) << 12 | 32'(r.rd) << 7 | 32'(r.op);
      3'd1: begin
        if (r.op == 7'h13 && (r.f3 == 3'd1 || r.f3 == 3'd5)) begin
          bad = bad || (r.imm > 32'd31);
          w   = 32'(r.f75) << 30 | (r.imm & 32'h1F) << 20 | 32'(r.rs1) << 15 |
                32'(r.f3) << 12 | 32'(r.rd) << 7 | 32'(r.op);
        end else begin
          bad = bad || (s < -2048) || (s > 2047);
          w   = (r.imm & 32'hFFF) << 20 | 32'(r.rs1) << 15 |
                32'(r.f3) << 12 | 32'(r.rd) << 7 | 32'(r.op);
        end
      end
      3'd2: begin
        bad = bad || (s < -2048) || (s > 2047);
        w   = ((r.imm >> 5) & 32'h7F) << 25 | 32'(r.rs2) << 20 | 32'(r.rs1) << 15 |
              32'(r.f3) << 12 | (r.imm & 32'h1F) << 7 | 32'(r.op);
      end
      3'd3: begin
        bad = bad || r.imm[0] || (s < -4096) || (s > 4095);
        w   = ((r.imm >> 12) & 32'h1) << 31 | ((r.imm >> 5) & 32'h3F) << 25 |
              32'(r.rs2) << 20 | 32'(r.rs1) << 15 | 32'(r.f3) << 12 |
              ((r.imm >> 1) & 32'hF) << 8 | ((r.imm >> 11) & 32'h1) << 7 | 32'(r.op);
      end
      3'd4: begin
        bad = bad || ((r.imm & 32'hFFF) != 0);
        w   = (r.imm & 32'hFFFF_F000) | 32'(r.rd) << 7 | 32'(r.op);
      end
      3'd5: begin
        bad = bad || r.imm[0] || (s < -1048576) || (s > 1048575);
        w   = ((r.imm >> 20) & 32'h1) << 31 | ((r.imm >> 1) & 32'h3FF) << 21 |
              ((r.imm >> 11) & 32'h1) << 20 | ((r.imm >> 12) & 32'hFF) << 12 |
              32'(r.rd) << 7 | 32'(r.op);
      end
      default: w = 32'h0;
    endcase
    if (bad) w = 32'h0000_0013;
    return {bad, w};
  endfunction

  function automatic req_t mk(input logic [2:0] fmt, input logic [6:0] op,
                              input logic [2:0] f3, input logic f75,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm);
    req_t r;
    r.fmt = fmt; r.op = op; r.f3 = f3; r.f75 = f75;
    r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.fmt = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    r.op  = {5'($urandom), ($urandom_range(0, 14) == 0) ? 2'($urandom_range(0, 2)) : 2'b11};
    r.f3  = 3'($urandom);
    r.f75 = 1'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    case ($urandom_range(0, 4))
      0:       r.imm = $urandom;
      1:       r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       r.imm = bl[$urandom_range(0, 14)];
      3:       r.imm = {20'($urandom), 12'h0};
      default: r.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'h1;
    endcase
    if (r.fmt == 3'd1 && $urandom_range(0, 2) == 0) begin
      r.op  = 7'h13;
      r.f3  = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
      r.imm = 32'($urandom_range(0, 63));
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    m_load  = 1'b1;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // One cycle of stimulus: optional request and optional finish. When
  // use_lit is set the expected word is the given literal, not the model.
  task automatic apply_stimulus(input req_t r, input bit valid, input bit finish,
                                input bit use_lit, input logic [31:0] lit);
    logic [32:0] enc;
    exp_t        e;
    bit          take;
    bus.i_valid    = valid;
    bus.i_finish   = finish;
    bus.i_fmt      = r.fmt;
    bus.i_opcode   = r.op;
    bus.i_funct3   = r.f3;
    bus.i_funct7_5 = r.f75;
    bus.i_rd       = r.rd;
    bus.i_rs1      = r.rs1;
    bus.i_rs2      = r.rs2;
    bus.i_imm      = r.imm;
    #1;
    check_output("ready", bus.o_ready, m_load && (m_count < DEPTH - 1) && !finish);
    take = valid && m_load && (m_count < DEPTH - 1);
    if (take) begin
      enc    = ref_encode(r);
      m_err  = m_err | enc[32];
      e.addr = AW'((BASE + m_count) % DEPTH);
      e.data = use_lit ? lit : enc[31:0];
      e.err  = m_err;
      sb.push_back(e);
      m_count++;
    end
    tick();
    bus.i_valid  = 1'b0;
    bus.i_finish = 1'b0;
    if (finish && m_load) begin
      m_load = 1'b0;
      e.addr = AW'((BASE + m_count) % DEPTH);
      e.data = 32'h0000_006F;
      e.err  = m_err;
      sb.push_back(e);
    end
    check_output("count", bus.o_count, m_count);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 30 && bus.o_done !== 1'b1; i++) tick();
    check_output({tag, "_done"}, bus.o_done, 1);
    check_output({tag, "_count"}, bus.o_count, m_count);
    check_output({tag, "_err"}, bus.o_err, m_err);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_we"}, bus.o_mem_we, 0);
    check_output({tag, "_addr"}, bus.o_mem_addr, 0);
    check_output({tag, "_wdata"}, bus.o_mem_wdata, 0);
    check_output({tag, "_ready"}, bus.o_ready, 0);
    check_output({tag, "_count"}, bus.o_count, 0);
    check_output({tag, "_err"}, bus.o_err, 0);
    check_output({tag, "_full"}, bus.o_full, 0);
    check_output({tag, "_done"}, bus.o_done, 0);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.o_mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_write", bus.o_mem_we, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("wr_addr", bus.o_mem_addr, e.addr);
        check_output("wr_data", bus.o_mem_wdata, e.data);
        check_output("wr_err", bus.o_err, e.err);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_t r;
    req_t idle;
    int   n;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_start = 1'b0; bus.i_finish = 1'b0; bus.i_valid = 1'b0;
    bus.i_fmt = '0; bus.i_opcode = '0; bus.i_funct3 = '0; bus.i_funct7_5 = 1'b0;
    bus.i_rd = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_imm = '0;

    tick(); tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single addi and its two-clock latency.
    do_start();
    apply_stimulus(mk(1, 7'h13, 0, 0, 1, 0, 0, 5), 1, 0, 1, 32'h0050_0093);
    check_output("lat_k1_we", bus.o_mem_we, 0);
    tick();
    check_output("lat_k2_we", bus.o_mem_we, 0);
    tick();
    check_output("lat_k3_we", bus.o_mem_we, 1);

    // Back-to-back sub / sw / beq, wrapping from address 7 to 0.
    apply_stimulus(mk(0, 7'h33, 0, 1, 3, 1, 2, 0), 1, 0, 1, 32'h4020_81B3);
    apply_stimulus(mk(2, 7'h23, 2, 0, 0, 1, 2, 4), 1, 0, 1, 32'h0020_A223);
    apply_stimulus(mk(3, 7'h63, 0, 0, 0, 1, 2, 8), 1, 0, 1, 32'h0020_8463);

    // Odd branch offset becomes a nop and raises the sticky error.
    apply_stimulus(mk(3, 7'h63, 0, 0, 0, 1, 2, 7), 1, 0, 1, 32'h0000_0013);
    apply_stimulus(mk(1, 7'h13, 0, 0, 4, 0, 0, 9), 1, 0, 0, 0);
    apply_stimulus(mk(1, 7'h13, 0, 0, 5, 0, 0, 10), 1, 0, 0, 0);
    check_output("full_flag", bus.o_full, 1);
    check_output("full_ready", bus.o_ready, 0);
    apply_stimulus(mk(1, 7'h13, 0, 0, 6, 0, 0, 11), 1, 0, 0, 0);
    apply_stimulus(idle, 0, 1, 0, 0);
    wait_done("full");

    do_start();
    check_output("restart_err", bus.o_err, 0);
    check_output("restart_done", bus.o_done, 0);
    check_output("restart_full", bus.o_full, 0);
    // Finish with an empty pipeline.
    apply_stimulus(idle, 0, 1, 0, 0);
    wait_done("empty");

    // Randomised sessions; the last request rides with i_finish.
    for (int s = 0; s < 40; s++) begin
      do_start();
      n = $urandom_range(1, 9);
      for (int j = 0; j < n; j++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        r = rand_req();
        apply_stimulus(r, 1, (j == n - 1), 0, 0);
      end
      wait_done("rand");
    end

    // Reset with the pipeline full: nothing further may be written.
    do_start();
    apply_stimulus(mk(1, 7'h13, 0, 0, 1, 0, 0, 1), 1, 0, 0, 0);
    apply_stimulus(mk(1, 7'h13, 0, 0, 2, 0, 0, 2), 1, 0, 0, 0);
    rst_n = 1'b0;
    sb.delete();
    m_load = 1'b0;
    #1;
    check_idle_outputs("abort");
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_idle_outputs("post_abort");

    check_output("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
